// File: rtl/alu_pkg.sv
// alu_pkg: sequencer state encoding and ALU opcode constants
package alu_pkg;
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SHOW} seq_state_t;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SLA = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_MAX = 4'b1001;
endpackage

// File: rtl/pulse_gen.sv
// pulse_gen: rising-edge detector, pulse = sig & ~sig_q
module pulse_gen (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);
  logic sig_q;
  always_ff @(posedge clk)
    sig_q <= rst ? 1'b0 : sig;
  assign pulse = sig & ~sig_q;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: three-press operand/op loader driving the ALU, captures result and Z/N/C/V flags
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic [3:0]   op_in,
  input  logic         load,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic [3:0]   select,
  output logic [N-1:0] result_q,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         op_err,
  output logic         done,
  output logic [2:0]   state_o
);
  seq_state_t state, state_nx;
  logic ld, arith;
  pulse_gen u_ld (.clk(clk), .rst(rst), .sig(load), .pulse(ld));
  assign arith = (select == OP_ADD) || (select == OP_SUB);
  assign state_o = state;
  always_comb begin
    state_nx = WAIT_A;
    case (state)
      WAIT_A:  state_nx = ld ? WAIT_B : WAIT_A;
      WAIT_B:  state_nx = ld ? WAIT_OP : WAIT_B;
      WAIT_OP: state_nx = ld ? EXEC : WAIT_OP;
      EXEC:    state_nx = SHOW;
      SHOW:    state_nx = ld ? WAIT_A : SHOW;
      default: state_nx = WAIT_A;
    endcase
  end
  always_ff @(posedge clk)
    state <= rst ? WAIT_A : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      select   <= '0;
      result_q <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      op_err   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= state_nx == SHOW;
      if (state == WAIT_A && ld) op_a <= data_in;
      if (state == WAIT_B && ld) op_b <= data_in;
      if (state == WAIT_OP && ld) begin
        select <= op_in > OP_MAX ? OP_ADD : op_in;
        op_err <= op_in > OP_MAX;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        flag_z   <= alu_result == '0;
        flag_n   <= alu_result[N-1];
        flag_c   <= arith & alu_carry;
        flag_v   <= arith & alu_overflow;
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: random and directed load sequences checked against a behavioural ALU/sequencer model
module tb_alu_operand_sequencer;
  logic clk = 0, rst, load, force_c;
  logic [3:0] data_in, op_in, alu_result, op_a, op_b, select, result_q;
  logic alu_carry, alu_carry_m, alu_overflow;
  logic flag_z, flag_n, flag_c, flag_v, op_err, done;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
  alu_operand_sequencer #(.N(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .op_in(op_in), .load(load),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .op_a(op_a), .op_b(op_b), .select(select), .result_q(result_q),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .op_err(op_err), .done(done), .state_o(state_o)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [4:0] t;
    logic [3:0] r;
    logic c, v;
    c = 0;
    v = 0;
    case (s)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'd1: begin r = a - b; c = a >= b; v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'd2: r = ~a;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = {a[3], a[3:1]};
      4'd7: r = a >> 1;
      4'd8: r = a << 1;
      4'd9: r = a << 1;
      default: r = 4'hF;
    endcase
    return {c, v, r};
  endfunction
  assign {alu_carry_m, alu_overflow, alu_result} = alu_f(op_a, op_b, select);
  assign alu_carry = alu_carry_m | force_c;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [3:0] d, input int hold);
    data_in = d;
    load = 1;
    repeat (hold) step();
    load = 0;
    step();
  endtask
  task automatic run3(input logic [3:0] op);
    op_in = op;
    load = 1;
    step();
    chk("exec_state", state_o, 3);
    chk("exec_done", done, 0);
    load = 0;
    step();
    chk("show_state", state_o, 4);
    chk("show_done", done, 1);
  endtask
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op, input int ha, input int hb);
    press(a, ha);
    press(b, hb);
    chk("op_a", op_a, a);
    chk("op_b", op_b, b);
    run3(op);
  endtask
  task automatic ack(input logic [3:0] er, input logic [3:0] ea);
    data_in = ~ea;
    load = 1;
    step();
    chk("ack_state", state_o, 0);
    chk("ack_done", done, 0);
    chk("ack_result", result_q, er);
    chk("ack_op_a", op_a, ea);
    load = 0;
    step();
  endtask
  initial begin
    logic [3:0] a, b, op, es, r;
    logic eo, c, v, fc, fv;
    rst = 1; load = 0; data_in = 0; op_in = 0; force_c = 0;
    step(); step();
    rst = 0;
    chk("rst0_state", state_o, 0);
    press(4'h9, 1);
    press(4'h6, 1);
    chk("pre_rst_state", state_o, 2);
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_state", state_o, 0);
    chk("rst_ops", {op_a, op_b, select}, 0);
    chk("rst_result", result_q, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, op_err, done}, 0);
    run(4'd5, 4'd3, 4'd0, 1, 1);
    chk("add_result", result_q, 4'b1000);
    chk("add_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0101);
    chk("add_err", op_err, 0);
    ack(4'b1000, 4'd5);
    run(4'd3, 4'd3, 4'd1, 1, 1);
    chk("sub_result", result_q, 0);
    chk("sub_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
    ack(4'd0, 4'd3);
    force_c = 1;
    run(4'd3, 4'd3, 4'd3, 1, 1);
    chk("and_result", result_q, 3);
    chk("and_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    chk("and_select", select, 3);
    force_c = 0;
    ack(4'd3, 4'd3);
    data_in = 4'd7;
    load = 1;
    step();
    data_in = 4'd2;
    repeat (9) step();
    chk("hold_op_a", op_a, 7);
    chk("hold_state", state_o, 1);
    load = 0;
    step();
    press(4'd9, 1);
    chk("hold_op_b", op_b, 9);
    chk("hold_state2", state_o, 2);
    run3(4'b1100);
    chk("err_select", select, 0);
    chk("err_flag", op_err, 1);
    chk("err_result", result_q, 0);
    chk("err_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b1010);
    ack(4'd0, 4'd7);
    run(4'd6, 4'd7, 4'd2, 1, 1);
    chk("not_err", op_err, 0);
    chk("not_result", result_q, 4'd9);
    chk("not_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);
    ack(4'd9, 4'd6);
    for (int i = 0; i < 30; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      op = 4'($urandom);
      force_c = 1'($urandom);
      eo = op > 9;
      es = eo ? 4'd0 : op;
      {c, v, r} = alu_f(a, b, es);
      fc = es < 2 ? (c | force_c) : 1'b0;
      fv = es < 2 ? v : 1'b0;
      run(a, b, op, 1 + int'($urandom_range(3)), 1 + int'($urandom_range(3)));
      chk("rnd_select", select, es);
      chk("rnd_err", op_err, eo);
      chk("rnd_result", result_q, r);
      chk("rnd_flags", {flag_z, flag_n, flag_c, flag_v}, {r == 0, r[3], fc, fv});
      step();
      chk("rnd_hold", {result_q, state_o, done}, {r, 3'd4, 1'b1});
      ack(r, a);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
